// File: rtl/babbage_pkg.sv
// Shared definitions for the babbage arbiter and its difference engine.
//   N_W   : width of the job argument n
//   F_W   : width of f(n) = n^3 + 2n^2 + 2n + 1 (f(63) = 258112 < 2^18)
//   CNT_W : width of the completed-response counter
package babbage_pkg;

    localparam int N_W   = 6;
    localparam int F_W   = 18;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_RESP
    } arb_state_t;

    typedef enum logic [1:0] {
        ENG_IDLE,
        ENG_STEP,
        ENG_DONE
    } eng_state_t;

endpackage

// File: rtl/babbage_diff.sv
// Difference-method engine for f(n) = n^3 + 2n^2 + 2n + 1.
// Starting from f(0) = 1 and the forward differences at k = 0
// (d1 = 5, d2 = 10, d3 = 6), each STEP cycle advances k by one using adds only.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : accepted only while ready is high
//   i           : argument n, sampled on the start cycle
//   ans         : f(i), valid while done_tick is high
//   ready       : engine idle, can take a start
//   done_tick   : one-cycle completion strobe, n+2 cycles after the start cycle
module babbage_diff
    import babbage_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N_W-1:0] i,
    output logic [F_W-1:0] ans,
    output logic           ready,
    output logic           done_tick
);

    localparam logic [F_W-1:0] F_INIT  = F_W'(1);
    localparam logic [F_W-1:0] D1_INIT = F_W'(5);
    localparam logic [F_W-1:0] D2_INIT = F_W'(10);
    localparam logic [F_W-1:0] D3      = F_W'(6);

    eng_state_t     state, state_next;
    logic [N_W-1:0] cnt_q;
    logic [F_W-1:0] f_q, d1_q, d2_q;

    always_comb begin
        state_next = state;
        case (state)
            ENG_IDLE: if (start) state_next = ENG_STEP;
            // cnt_q counts remaining steps; the zero check costs one extra
            // cycle, which gives the fixed n+2 start-to-done latency.
            ENG_STEP: if (cnt_q == '0) state_next = ENG_DONE;
            ENG_DONE: state_next = ENG_IDLE;
            default:  state_next = ENG_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ENG_IDLE;
            cnt_q <= '0;
            f_q   <= '0;
            d1_q  <= '0;
            d2_q  <= '0;
        end else begin
            state <= state_next;
            if (state == ENG_IDLE && start) begin
                cnt_q <= i;
                f_q   <= F_INIT;
                d1_q  <= D1_INIT;
                d2_q  <= D2_INIT;
            end else if (state == ENG_STEP && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
                f_q   <= f_q + d1_q;
                d1_q  <= d1_q + d2_q;
                d2_q  <= d2_q + D3;
            end
        end
    end

    assign ans       = f_q;
    assign ready     = (state == ENG_IDLE);
    assign done_tick = (state == ENG_DONE);

endmodule

// File: rtl/babbage_arb.sv
// Two-requester round-robin front end for the babbage_diff engine.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   reqX_valid / reqX_n    : requester X job request and argument
//   reqX_ready             : one-cycle accept strobe for requester X
//   rsp_valid / rsp_id     : result pending, and which requester owns it
//   rsp_data               : f(n) for the accepted job
//   rsp_ready              : consumer accepts the result
//   busy                   : a job is in flight (any state but IDLE)
//   job_cnt                : completed responses, saturating at all-ones
module babbage_arb
    import babbage_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [N_W-1:0]   req0_n,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [N_W-1:0]   req1_n,
    output logic             req1_ready,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [F_W-1:0]   rsp_data,
    input  logic             rsp_ready,
    output logic             busy,
    output logic [CNT_W-1:0] job_cnt
);

    arb_state_t     state, state_next;
    logic           rr;
    logic [N_W-1:0] n_q;
    logic           id_q;

    logic           accept;
    logic           grant_id;
    logic [N_W-1:0] grant_n;
    logic           eng_start;
    logic [F_W-1:0] eng_ans;
    logic           eng_ready;
    logic           eng_done;

    babbage_diff u_engine (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (eng_start),
        .i         (n_q),
        .ans       (eng_ans),
        .ready     (eng_ready),
        .done_tick (eng_done)
    );

    always_comb begin
        // rr only matters under contention; a lone requester always wins.
        if (req0_valid && req1_valid) grant_id = rr;
        else                          grant_id = req1_valid;
        grant_n    = grant_id ? req1_n : req0_n;
        state_next = state;
        accept     = 1'b0;
        eng_start  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req0_valid || req1_valid) begin
                    accept     = 1'b1;
                    state_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                eng_start = 1'b1;
                if (eng_ready) state_next = ST_WAIT;
            end
            ST_WAIT:   if (eng_done)  state_next = ST_RESP;
            ST_RESP:   if (rsp_ready) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            rr       <= 1'b0;
            n_q      <= '0;
            id_q     <= 1'b0;
            rsp_data <= '0;
            job_cnt  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                n_q  <= grant_n;
                id_q <= grant_id;
            end
            if (state == ST_WAIT && eng_done)
                rsp_data <= eng_ans;
            if (state == ST_RESP && rsp_ready) begin
                if (job_cnt != '1) job_cnt <= job_cnt + 1'b1;
                rr <= ~id_q;
            end
        end
    end

    // State is already IDLE during reset, so the readys are gated by rst_n
    // to keep a held-high valid from pulsing an accept while reset is low.
    assign req0_ready = rst_n & accept & ~grant_id;
    assign req1_ready = rst_n & accept &  grant_id;
    assign rsp_valid  = (state == ST_RESP);
    assign rsp_id     = id_q;
    assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_babbage_arb.sv
// Directed bench for babbage_arb: latency, arbitration, back-pressure,
// mid-job reset and counter saturation.
module tb_babbage_arb;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [5:0]  req0_n, req1_n;
    logic        req0_ready, req1_ready;
    logic        rsp_valid, rsp_id, rsp_ready, busy;
    logic [17:0] rsp_data;
    logic [15:0] job_cnt;

    int checks   = 0;
    int failures = 0;

    babbage_arb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_n     (req0_n),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_n     (req1_n),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_ready  (rsp_ready),
        .busy       (busy),
        .job_cnt    (job_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus helper: request a job, wait for accept, then count cycles until
    // rsp_valid first rises (accept cycle = 0). Returns the observed response.
    task automatic do_job(input bit id, input logic [5:0] n, output int lat,
                          output logic rid, output logic [17:0] data, output bit tmo);
        int w;
        tmo = 0;
        @(negedge clk);
        if (id) begin req1_valid = 1; req1_n = n; end
        else    begin req0_valid = 1; req0_n = n; end
        #1;
        w = 0;
        while (!(id ? req1_ready : req0_ready) && w < 100) begin
            @(negedge clk); #1; w++;
        end
        if (w >= 100) tmo = 1;
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        #1;
        lat = 1;
        while (!rsp_valid && lat < 200) begin
            @(negedge clk); #1; lat++;
        end
        if (!rsp_valid) tmo = 1;
        rid  = rsp_id;
        data = rsp_data;
    endtask

    task automatic test_reset();
        rst_n = 0; req0_valid = 1; req1_valid = 1; req0_n = 6'd5; req1_n = 6'd9; rsp_ready = 1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl busy=%b rsp_valid=%b rdy0=%b rdy1=%b required all 0", busy, rsp_valid, req0_ready, req1_ready);
        end
        checks++;
        if (job_cnt !== 16'h0 || rsp_data !== 18'h0) begin
            failures++;
            $display("FAIL reset_data job_cnt=%h rsp_data=%0d required 0/0", job_cnt, rsp_data);
        end
        @(negedge clk);
        req0_valid = 0; req1_valid = 0; rst_n = 1;
    endtask

    task automatic test_basic();
        int lat; logic rid; logic [17:0] d; bit tmo;
        rsp_ready = 1;
        do_job(1'b0, 6'd3, lat, rid, d, tmo);
        checks++;
        if (tmo || lat !== 7) begin
            failures++;
            $display("FAIL basic_latency lat=%0d tmo=%0b required 7", lat, tmo);
        end
        checks++;
        if (rid !== 1'b0 || d !== 18'd52) begin
            failures++;
            $display("FAIL basic_rsp id=%b data=%0d required 0/52", rid, d);
        end
        @(negedge clk); #1;
        checks++;
        if (job_cnt !== 16'd1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_cnt job_cnt=%0d busy=%b required 1/0", job_cnt, busy);
        end
    endtask

    task automatic test_req1_edges();
        int lat; logic rid; logic [17:0] d; bit tmo;
        rsp_ready = 1;
        do_job(1'b1, 6'd0, lat, rid, d, tmo);
        checks++;
        if (tmo || lat !== 4 || rid !== 1'b1 || d !== 18'd1) begin
            failures++;
            $display("FAIL n0 lat=%0d id=%b data=%0d tmo=%0b required 4/1/1", lat, rid, d, tmo);
        end
        do_job(1'b1, 6'd63, lat, rid, d, tmo);
        checks++;
        if (tmo || lat !== 67 || rid !== 1'b1 || d !== 18'd258112) begin
            failures++;
            $display("FAIL n63 lat=%0d id=%b data=%0d tmo=%0b required 67/1/258112", lat, rid, d, tmo);
        end
    endtask

    task automatic test_back_to_back();
        int grants, cyc, last_cyc, nrsp;
        logic exp_id;
        bit both;
        grants = 0; cyc = 0; last_cyc = -1; nrsp = 0; both = 0; exp_id = 0;
        rsp_ready = 1;
        @(negedge clk);
        req0_valid = 1; req1_valid = 1; req0_n = 6'd2; req1_n = 6'd2;
        while (grants < 4 && cyc < 200) begin
            #1;
            if (req0_ready && req1_ready) both = 1;
            if (rsp_valid) begin
                nrsp++;
                checks++;
                if (rsp_data !== 18'd21 || rsp_id !== ~exp_id) begin
                    failures++;
                    $display("FAIL b2b_rsp data=%0d id=%b required 21/%b", rsp_data, rsp_id, ~exp_id);
                end
            end
            if (req0_ready || req1_ready) begin
                checks++;
                if (req1_ready !== exp_id) begin
                    failures++;
                    $display("FAIL b2b_grant%0d granted=%b required %b", grants, req1_ready, exp_id);
                end
                if (last_cyc >= 0) begin
                    checks++;
                    if (cyc - last_cyc !== 7) begin
                        failures++;
                        $display("FAIL b2b_gap gap=%0d required 7", cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                exp_id = ~exp_id;
                grants++;
            end
            @(negedge clk);
            cyc++;
        end
        req0_valid = 0; req1_valid = 0;
        checks++;
        if (grants !== 4 || both || nrsp !== 3) begin
            failures++;
            $display("FAIL b2b_summary grants=%0d both_ready=%0b rsps=%0d required 4/0/3", grants, both, nrsp);
        end
        cyc = 0;
        #1;
        while (busy && cyc < 100) begin @(negedge clk); #1; cyc++; end
    endtask

    task automatic test_stall();
        int lat, cyc; logic rid; logic [17:0] d; bit tmo;
        rsp_ready = 0;
        do_job(1'b0, 6'd5, lat, rid, d, tmo);
        checks++;
        if (tmo || lat !== 9 || rid !== 1'b0 || d !== 18'd186) begin
            failures++;
            $display("FAIL stall_first lat=%0d id=%b data=%0d tmo=%0b required 9/0/186", lat, rid, d, tmo);
        end
        req1_valid = 1; req1_n = 6'd7;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 18'd186 ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold%0d valid=%b id=%b data=%0d rdy=%b%b required 1/0/186/00",
                         k, rsp_valid, rsp_id, rsp_data, req1_ready, req0_ready);
            end
        end
        @(negedge clk);
        rsp_ready = 1;
        #1;
        checks++;
        if (rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall_hs_cycle valid=%b required 1", rsp_valid);
        end
        @(negedge clk); #1;
        checks++;
        if (req1_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_next_accept rdy1=%b busy=%b valid=%b required 1/0/0", req1_ready, busy, rsp_valid);
        end
        @(negedge clk);
        req1_valid = 0;
        #1;
        cyc = 0;
        while (!rsp_valid && cyc < 100) begin @(negedge clk); #1; cyc++; end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 18'd456) begin
            failures++;
            $display("FAIL stall_second valid=%b id=%b data=%0d required 1/1/456", rsp_valid, rsp_id, rsp_data);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int cyc; bit seen;
        rsp_ready = 1;
        @(negedge clk);
        req0_valid = 1; req0_n = 6'd40;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_accept rdy0=%b required 1", req0_ready);
        end
        @(negedge clk);
        req0_valid = 0;
        repeat (10) @(negedge clk);
        req0_valid = 1; rst_n = 0;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0 ||
            job_cnt !== 16'h0 || rsp_data !== 18'h0) begin
            failures++;
            $display("FAIL rstmid_clear busy=%b valid=%b rdy=%b%b cnt=%0d data=%0d required all 0",
                     busy, rsp_valid, req1_ready, req0_ready, job_cnt, rsp_data);
        end
        @(negedge clk);
        rst_n = 1; req0_valid = 0;
        seen = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk); #1;
            if (rsp_valid || busy) seen = 1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL rstmid_no_rsp activity=%0b required 0", seen);
        end
        // first contention after reset goes to requester 0
        @(negedge clk);
        req0_valid = 1; req1_valid = 1; req0_n = 6'd1; req1_n = 6'd1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_first_grant rdy=%b%b required 01", req1_ready, req0_ready);
        end
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        #1;
        cyc = 1;
        while (!rsp_valid && cyc < 100) begin @(negedge clk); #1; cyc++; end
        checks++;
        if (cyc !== 5 || rsp_data !== 18'd6 || rsp_id !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_n1 lat=%0d data=%0d id=%b required 5/6/0", cyc, rsp_data, rsp_id);
        end
        @(negedge clk); #1;
        checks++;
        if (job_cnt !== 16'd1) begin
            failures++;
            $display("FAIL rstmid_cnt job_cnt=%0d required 1", job_cnt);
        end
    endtask

    task automatic test_saturate();
        int lat; logic rid; logic [17:0] d; bit tmo;
        rsp_ready = 1;
        @(negedge clk);
        force dut.job_cnt = 16'hFFFE;
        #1;
        release dut.job_cnt;
        for (int k = 0; k < 3; k++) begin
            do_job(1'b0, 6'd0, lat, rid, d, tmo);
            @(negedge clk); #1;
            checks++;
            if (tmo || job_cnt !== 16'hFFFF) begin
                failures++;
                $display("FAIL sat_job%0d job_cnt=%h tmo=%0b required ffff", k, job_cnt, tmo);
            end
        end
    endtask

    initial begin
        rst_n = 0; req0_valid = 0; req1_valid = 0; req0_n = '0; req1_n = '0; rsp_ready = 0;
        test_reset();
        test_basic();
        test_req1_edges();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/babbage_arb.md
BABBAGE_ARB -- requirements
Module: babbage_arb

Interface
REQ-001 The block SHALL have exactly one clock and one reset: the reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req0_valid  input  1  requester 0 has a job pending.
REQ-005 req0_n  input  6  requester 0 argument n, valid while req0_valid is high.
REQ-006 req0_ready  output  1  one-cycle accept strobe for requester 0.
REQ-007 req1_valid, req1_n, req1_ready SHALL mirror REQ-004 to REQ-006 for requester 1.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_id  output  1  requester the result belongs to.
REQ-010 rsp_data  output  18  f(n) = n^3 + 2n^2 + 2n + 1.
REQ-011 rsp_ready  input  1  consumer accepts the result.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 job_cnt  output  16  count of completed responses, saturating at 0xFFFF.

Function
REQ-014 The FSM SHALL have four states, IDLE, LAUNCH, WAIT and RESP, with IDLE as the reset state.
REQ-015 IDLE, at least one valid: grant one requester, pulse its reqX_ready in that same cycle, latch its n into n_q and its index into id_q, then go to LAUNCH.
REQ-016 IDLE, both valid in the same cycle: grant the requester selected by the round-robin pointer rr.
REQ-017 rr SHALL change only on a response handshake, and SHALL then point to the requester other than id_q.
REQ-018 IDLE, only one valid: grant that requester regardless of rr.
REQ-019 LAUNCH SHALL assert engine start for exactly one cycle and then go to WAIT.
REQ-020 The engine argument SHALL be driven from n_q and held stable from LAUNCH until the engine asserts done.
REQ-021 WAIT, engine done_tick high: capture engine ans into rsp_data and go to RESP.
REQ-022 RESP SHALL hold rsp_valid high, with rsp_id = id_q and rsp_data stable, until rsp_ready is high.
REQ-023 On the RESP handshake cycle (rsp_valid and rsp_ready both high): increment job_cnt if it is below 0xFFFF, update rr, and go to IDLE.
REQ-024 rsp_ready high in the same cycle rsp_valid rises SHALL complete the handshake in that cycle.
REQ-025 req0_ready and req1_ready SHALL be low in every state except the IDLE accept cycle, and SHALL never both be high.
REQ-026 Latency SHALL be fixed: accept in cycle T, start in T+1, engine done_tick in T+n+3, rsp_valid first high in T+n+4.
REQ-027 The earliest next accept SHALL be the cycle after the response handshake.
REQ-028 All n from 0 to 63 SHALL be legal; f(63) = 258112 fits in 18 bits, so no overflow handling is required.
REQ-029 The engine ready output SHALL be monitored: if the engine is not ready in LAUNCH, the FSM SHALL hold in LAUNCH with start asserted until the engine is ready.

Reset
REQ-030 While rst_n is low, the block SHALL immediately clear state, rr, n_q, id_q, rsp_data and job_cnt, and drive rsp_valid, req0_ready, req1_ready and busy to 0.
REQ-031 A reset during LAUNCH, WAIT or RESP SHALL abort the job with no response, and the engine instance SHALL be reset by the same rst_n.
REQ-032 After reset release, the first contention SHALL grant requester 0.

Structure
REQ-033 Package babbage_pkg SHALL hold the state enumeration and the width constants N_W=6, F_W=18 and CNT_W=16.
REQ-034 The block SHALL contain exactly one sub-module, the babbage_diff engine instance u_engine.
REQ-035 The engine SHALL implement the difference method for f(n): ports clk, rst_n, start, i[5:0], ans[17:0], ready and done_tick.

Verification
REQ-036 Scenario: req0 with n=3 accepted at T, rsp_ready tied high -> rsp_valid in T+7, rsp_id=0, rsp_data=52, job_cnt=1.
REQ-037 Scenario: req1 with n=0 -> rsp_data=1 in T+4; then n=63 -> rsp_data=258112 in T+67.
REQ-038 Scenario: both requesters hold valid continuously with n=2 -> grants alternate 0,1,0,1 and every rsp_data=21.
REQ-039 Scenario: rsp_ready held low for 10 cycles in RESP -> rsp_valid, rsp_id and rsp_data stay stable, both readys stay low, and the handshake occurs on the cycle rsp_ready rises.
REQ-040 Scenario: rst_n pulsed low during WAIT of an n=40 job -> all outputs reach their reset values immediately, no response appears, and the next job with n=1 returns 6.
REQ-041 Scenario: job_cnt preloaded to 0xFFFE by forcing, then three jobs complete -> job_cnt ends at 0xFFFF.
